id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS core, feeding the ALU directly. It captures decoded operands from the decode stage and resolves data hazards. Register bypassing is applied at capture time from the EX, MEM and WB stages. The registered outputs drive the ALU's A, B, ALU_Sel, CarryIn and Sign inputs. The block also detects load-use hazards, inserts bubbles, and honours the global stall and flush.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fwd_mux.sv | 46 ++++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths and the forwarding-source encoding.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ALU_SEL_W  = 4;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass mux for one source register: EX beats MEM beats WB beats register file.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic                  ex_en,
    input  logic [REG_ADDR_W-1:0] ex_addr,
    input  logic [WIDTH-1:0]      ex_data,
    input  logic                  mem_en,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic [WIDTH-1:0]      fwd_data,
    output fwd_src_e              fwd_src
);

    always_comb begin
        fwd_src = FWD_RF;
        // r0 is hardwired to zero, so no producer may ever override it
        if (src_addr != '0) begin
            if (ex_en && (ex_addr == src_addr)) begin
                fwd_src = FWD_EX;
            end else if (mem_en && (mem_addr == src_addr)) begin
                fwd_src = FWD_MEM;
            end else if (wb_en && (wb_addr == src_addr)) begin
                fwd_src = FWD_WB;
            end
        end
    end

    always_comb begin
        fwd_data = rf_data;
        case (fwd_src)
            FWD_EX:  fwd_data = ex_data;
            FWD_MEM: fwd_data = mem_data;
            FWD_WB:  fwd_data = wb_data;
            default: fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with capture-time bypassing,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEL_W = ALU_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [WIDTH-1:0]      id_rs_val,
    input  logic [WIDTH-1:0]      id_rt_val,
    input  logic [15:0]           id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_imm_zext,
    input  logic [SEL_W-1:0]      id_alu_sel,
    input  logic                  id_carry_in,
    input  logic                  id_sign,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [WIDTH-1:0]      ex_result,
    input  logic                  mem_fwd_en,
    input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
    input  logic [WIDTH-1:0]      mem_fwd_data,
    input  logic                  wb_fwd_en,
    input  logic [REG_ADDR_W-1:0] wb_fwd_addr,
    input  logic [WIDTH-1:0]      wb_fwd_data,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  alu_carry_in,
    output logic                  alu_sign,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [WIDTH-1:0]      ex_store_data,
    output logic [15:0]           hazard_count
);

    logic                  ex_valid_reg;
    logic [WIDTH-1:0]      alu_a_reg;
    logic [WIDTH-1:0]      alu_b_reg;
    logic [SEL_W-1:0]      alu_sel_reg;
    logic                  alu_carry_in_reg;
    logic                  alu_sign_reg;
    logic [REG_ADDR_W-1:0] ex_rd_addr_reg;
    logic                  ex_reg_write_reg;
    logic                  ex_mem_read_reg;
    logic [WIDTH-1:0]      ex_store_data_reg;
    logic [15:0]           hazard_count_reg;

    // A load still in EX has no data yet, so it is excluded from the EX bypass
    logic ex_fwd_en;
    assign ex_fwd_en = ex_valid_reg & ex_reg_write_reg & ~ex_mem_read_reg;

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [WIDTH-1:0]      src_rf   [2];
    logic [WIDTH-1:0]      src_fwd  [2];
    fwd_src_e              fwd_src_unused [2];

    assign src_addr[0] = id_rs_addr;
    assign src_addr[1] = id_rt_addr;
    assign src_rf[0]   = id_rs_val;
    assign src_rf[1]   = id_rt_val;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(.WIDTH(WIDTH)) u_fwd_mux (
                .src_addr (src_addr[gi]),
                .rf_data  (src_rf[gi]),
                .ex_en    (ex_fwd_en),
                .ex_addr  (ex_rd_addr_reg),
                .ex_data  (ex_result),
                .mem_en   (mem_fwd_en),
                .mem_addr (mem_fwd_addr),
                .mem_data (mem_fwd_data),
                .wb_en    (wb_fwd_en),
                .wb_addr  (wb_fwd_addr),
                .wb_data  (wb_fwd_data),
                .fwd_data (src_fwd[gi]),
                .fwd_src  (fwd_src_unused[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] imm_ext;
    assign imm_ext = id_imm_zext ? {{(WIDTH-16){1'b0}}, id_imm}
                                 : {{(WIDTH-16){id_imm[15]}}, id_imm};

    always_comb begin
        hazard_stall = 1'b0;
        if (id_valid && ex_valid_reg && ex_mem_read_reg && (ex_rd_addr_reg != '0)) begin
            hazard_stall = (ex_rd_addr_reg == id_rs_addr) ||
                           ((ex_rd_addr_reg == id_rt_addr) && !id_use_imm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg      <= 1'b0;
            alu_a_reg         <= '0;
            alu_b_reg         <= '0;
            alu_sel_reg       <= '0;
            alu_carry_in_reg  <= 1'b0;
            alu_sign_reg      <= 1'b0;
            ex_rd_addr_reg    <= '0;
            ex_reg_write_reg  <= 1'b0;
            ex_mem_read_reg   <= 1'b0;
            ex_store_data_reg <= '0;
            hazard_count_reg  <= '0;
        end else if (flush) begin
            ex_valid_reg     <= 1'b0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
        end else if (stall) begin
            ex_valid_reg <= ex_valid_reg;
        end else if (hazard_stall) begin
            ex_valid_reg     <= 1'b0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            if (hazard_count_reg != 16'hFFFF) begin
                hazard_count_reg <= hazard_count_reg + 16'd1;
            end
        end else begin
            ex_valid_reg      <= id_valid;
            alu_a_reg         <= src_fwd[0];
            alu_b_reg         <= id_use_imm ? imm_ext : src_fwd[1];
            alu_sel_reg       <= id_alu_sel;
            alu_carry_in_reg  <= id_carry_in;
            alu_sign_reg      <= id_sign;
            ex_rd_addr_reg    <= id_rd_addr;
            ex_reg_write_reg  <= id_valid & id_reg_write;
            ex_mem_read_reg   <= id_valid & id_mem_read;
            ex_store_data_reg <= src_fwd[1];
        end
    end

    assign ex_valid      = ex_valid_reg;
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_sel       = alu_sel_reg;
    assign alu_carry_in  = alu_carry_in_reg;
    assign alu_sign      = alu_sign_reg;
    assign ex_rd_addr    = ex_rd_addr_reg;
    assign ex_reg_write  = ex_reg_write_reg;
    assign ex_mem_read   = ex_mem_read_reg;
    assign ex_store_data = ex_store_data_reg;
    assign hazard_count  = hazard_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: predicted EX state is queued on drive, compared after the edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
    logic [31:0] id_rs_val = '0, id_rt_val = '0;
    logic [15:0] id_imm = '0;
    logic        id_use_imm = 1'b0, id_imm_zext = 1'b0;
    logic [3:0]  id_alu_sel = '0;
    logic        id_carry_in = 1'b0, id_sign = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic [31:0] ex_result = '0;
    logic        mem_fwd_en = 1'b0, wb_fwd_en = 1'b0;
    logic [4:0]  mem_fwd_addr = '0, wb_fwd_addr = '0;
    logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
    logic        hazard_stall, ex_valid, alu_carry_in, alu_sign, ex_reg_write, ex_mem_read;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_sel;
    logic [4:0]  ex_rd_addr;
    logic [15:0] hazard_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_imm_zext(id_imm_zext), .id_alu_sel(id_alu_sel),
        .id_carry_in(id_carry_in), .id_sign(id_sign), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_result(ex_result),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_carry_in(alu_carry_in), .alu_sign(alu_sign),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_store_data(ex_store_data), .hazard_count(hazard_count)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] a, b;
        logic [3:0]  sel;
        logic        ci, sg;
        logic [4:0]  rd;
        logic        rw, mr;
        logic [31:0] st;
        logic [15:0] hc;
    } exp_t;

    exp_t cur = '0;
    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (cur.v && cur.rw && !cur.mr && cur.rd == a) return ex_result;
        if (mem_fwd_en && mem_fwd_addr == a) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_addr == a) return wb_fwd_data;
        return rf;
    endfunction

    function automatic logic model_haz();
        return id_valid && cur.v && cur.mr && cur.rd != 5'd0 &&
               (cur.rd == id_rs_addr || (cur.rd == id_rt_addr && !id_use_imm));
    endfunction

    function automatic exp_t predict();
        exp_t n = cur;
        logic [31:0] ext = id_imm_zext ? {16'h0, id_imm} : {{16{id_imm[15]}}, id_imm};
        if (flush) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
        end else if (stall) begin
            n = cur;
        end else if (model_haz()) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
            if (cur.hc != 16'hFFFF) n.hc = cur.hc + 16'd1;
        end else begin
            n.v   = id_valid;
            n.a   = model_fwd(id_rs_addr, id_rs_val);
            n.st  = model_fwd(id_rt_addr, id_rt_val);
            n.b   = id_use_imm ? ext : n.st;
            n.sel = id_alu_sel; n.ci = id_carry_in; n.sg = id_sign;
            n.rd  = id_rd_addr;
            n.rw  = id_valid & id_reg_write;
            n.mr  = id_valid & id_mem_read;
        end
        return n;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk($sformatf("%s.ex_valid", tag), {31'd0, ex_valid}, {31'd0, e.v});
        chk($sformatf("%s.alu_a", tag), alu_a, e.a);
        chk($sformatf("%s.alu_b", tag), alu_b, e.b);
        chk($sformatf("%s.alu_sel", tag), {28'd0, alu_sel}, {28'd0, e.sel});
        chk($sformatf("%s.ci_sign", tag), {30'd0, alu_carry_in, alu_sign}, {30'd0, e.ci, e.sg});
        chk($sformatf("%s.rd", tag), {27'd0, ex_rd_addr}, {27'd0, e.rd});
        chk($sformatf("%s.rw_mr", tag), {30'd0, ex_reg_write, ex_mem_read}, {30'd0, e.rw, e.mr});
        chk($sformatf("%s.store", tag), ex_store_data, e.st);
        chk($sformatf("%s.hcount", tag), {16'd0, hazard_count}, {16'd0, e.hc});
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        #1;
        chk($sformatf("%s.hazard_stall", tag), {31'd0, hazard_stall}, {31'd0, model_haz()});
        q.push_back(predict());
        @(posedge clk);
        #1;
        e = q.pop_front();
        check_out(tag, e);
        cur = e;
        $display("txn %-16s ex_valid=%0d alu_a=%08h alu_b=%08h rd=%0d hcount=%0d",
                 tag, ex_valid, alu_a, alu_b, ex_rd_addr, hazard_count);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                          input logic [3:0] sel, input logic rw, input logic mr);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_alu_sel = sel;
        id_reg_write = rw; id_mem_read = mr;
        id_use_imm = 1'b0; id_imm_zext = 1'b0; id_imm = '0;
        id_carry_in = 1'b0; id_sign = 1'b0;
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
    endtask

    task automatic load_use_pair(input string tag);
        set_id(1'b1, 5'd1, 5'd7, 5'd7, 32'h100, 32'h0, 4'b0010, 1'b1, 1'b1);
        id_use_imm = 1'b1; id_imm = 16'h0004;
        cycle($sformatf("%s_lw", tag));
        set_id(1'b1, 5'd7, 5'd2, 5'd9, 32'h0, 32'h2, 4'b0010, 1'b1, 1'b0);
        cycle($sformatf("%s_use", tag));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", '0);
        chk("reset.hazard_stall", {31'd0, hazard_stall}, 32'd0);
        rst_n = 1'b1;

        // plain capture
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h10, 32'h20, 4'b0010, 1'b1, 1'b0);
        id_carry_in = 1'b1;
        cycle("plain");
        chk("plain.a_const", alu_a, 32'h10);
        chk("plain.b_const", alu_b, 32'h20);

        // forwarding priority on rs=5: EX holds rd=5 write
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 32'h99, 32'h33, 4'b0110, 1'b1, 1'b0);
        ex_result = 32'hA;
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hB;
        wb_fwd_en = 1'b1;  wb_fwd_addr = 5'd5;  wb_fwd_data = 32'hC;
        cycle("prio_ex");
        chk("prio_ex.const", alu_a, 32'hA);
        set_id(1'b1, 5'd5, 5'd5, 5'd0, 32'h99, 32'h98, 4'b0110, 1'b1, 1'b0);
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'hB;
        wb_fwd_en = 1'b1;  wb_fwd_addr = 5'd5;  wb_fwd_data = 32'hC;
        cycle("prio_mem");
        chk("prio_mem.const", alu_a, 32'hB);
        chk("prio_mem.store", ex_store_data, 32'hB);
        set_id(1'b1, 5'd0, 5'd6, 5'd8, 32'h77, 32'h66, 4'b0001, 1'b1, 1'b0);
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'hB;
        wb_fwd_en = 1'b1;  wb_fwd_addr = 5'd6;  wb_fwd_data = 32'hC;
        cycle("r0_and_wb");
        chk("r0.const", alu_a, 32'h77);
        chk("wb.const", alu_b, 32'hC);

        // immediates
        set_id(1'b1, 5'd2, 5'd3, 5'd4, 32'h1, 32'h5555, 4'b0010, 1'b1, 1'b0);
        id_use_imm = 1'b1; id_imm = 16'hFFF6; id_imm_zext = 1'b0; id_sign = 1'b1;
        cycle("imm_sext");
        chk("imm_sext.const", alu_b, 32'hFFFF_FFF6);
        chk("imm_sext.store", ex_store_data, 32'h5555);
        id_imm_zext = 1'b1;
        cycle("imm_zext");
        chk("imm_zext.const", alu_b, 32'h0000_FFF6);

        // load-use: one bubble, then MEM path delivers the load
        load_use_pair("lu");
        chk("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu.count", {16'd0, hazard_count}, 32'd1);
        mem_fwd_en = 1'b1; mem_fwd_addr = 5'd7; mem_fwd_data = 32'h1234;
        cycle("lu_resolve");
        chk("lu_resolve.const", alu_a, 32'h1234);
        chk("lu_resolve.valid", {31'd0, ex_valid}, 32'd1);

        // load in EX, consumer uses rt only as store/imm slot: no hazard
        set_id(1'b1, 5'd1, 5'd8, 5'd8, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b1);
        cycle("lw8");
        set_id(1'b1, 5'd2, 5'd8, 5'd3, 32'h4, 32'h0, 4'b0010, 1'b1, 1'b0);
        id_use_imm = 1'b1; id_imm = 16'h0010;
        cycle("imm_no_haz");

        // global stall holds everything for three cycles
        set_id(1'b1, 5'd10, 5'd11, 5'd12, 32'hCAFE, 32'hBEEF, 4'b0111, 1'b1, 1'b0);
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd13, 5'd14, 5'd15, 32'h1000 + i, 32'h2000 + i, 4'b1111, 1'b1, 1'b1);
            cycle($sformatf("stall%0d", i));
        end
        chk("stall.a_const", alu_a, 32'hCAFE);
        flush = 1'b1;
        cycle("flush_stall");
        chk("flush_stall.valid", {31'd0, ex_valid}, 32'd0);
        stall = 1'b0;
        load_use_pair("flush_haz");
        stall = 1'b0; flush = 1'b0;

        // invalid decode slot must not enable writes
        set_id(1'b0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 4'b0010, 1'b1, 1'b1);
        cycle("id_invalid");
        chk("id_invalid.rw", {31'd0, ex_reg_write}, 32'd0);

        // saturation: preload near the ceiling, then two more bubbles
        force dut.hazard_count_reg = 16'hFFFE;
        #1;
        release dut.hazard_count_reg;
        chk("preload", {16'd0, hazard_count}, 32'h0000_FFFE);
        cur.hc = 16'hFFFE;
        load_use_pair("sat1");
        chk("sat1.const", {16'd0, hazard_count}, 32'h0000_FFFF);
        load_use_pair("sat2");
        chk("sat2.const", {16'd0, hazard_count}, 32'h0000_FFFF);

        // asynchronous reset mid-stream, with stall and flush also high
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h55, 32'h66, 4'b0011, 1'b1, 1'b0);
        cycle("pre_rst");
        #2;
        stall = 1'b1; flush = 1'b1;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", '0);
        cur = '0;
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        cycle("post_rst");
        chk("post_rst.const", alu_a, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
